freq_divider_multi: RTL and testbench

Parametrised multi-channel clock divider, successor to the single fixed-K divider. Each channel produces a 50%-duty divided clock F2[i] and a one-cycle enable pulse tick[i], from one shared input clock F1. Divide ratios are runtime-programmable through a shared load bus, with glitch-free commit at period boundaries. Feeds the traffic-light timing logic: 1 Hz phase timer, display scan and blink clocks.

---
 rtl/freq_divider_multi.sv | 89 ++++++++
 tb/tb_freq_divider_multi.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_divider_multi.sv
// rtl/freq_divider_multi.sv - multi-channel programmable 50%-duty clock divider with tick pulses
// Define FREQ_DIV_ERR_EN to add the div_err output flagging zero-value loads.
module freq_divider_multi #(
  parameter int CHANNELS    = 3,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 5
) (
  input  logic                F1,
  input  logic                rst,
  input  logic                en,
  input  logic                sync,
  input  logic [CHANNELS-1:0] div_load,
  input  logic [CNT_W-1:0]    div_value,
`ifdef FREQ_DIV_ERR_EN
  output logic                div_err,
`endif
  output logic [CHANNELS-1:0] F2,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic value_ok;

  assign value_ok = |div_value;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] pend;
    logic [CNT_W-1:0] next_div;
    logic             pend_v;
    logic             f2_q;
    logic             tick_q;
    logic             load_ok;
    logic             terminal;

    assign load_ok  = div_load[i] && value_ok;
    assign terminal = (cnt == active - CNT_W'(1));
    // A load landing on the commit edge beats any older pending value.
    assign next_div = load_ok ? div_value : (pend_v ? pend : active);

    always_ff @(posedge F1 or posedge rst) begin
      if (rst) begin
        cnt    <= '0;
        active <= DIV_RST;
        pend   <= '0;
        pend_v <= 1'b0;
        f2_q   <= 1'b0;
        tick_q <= 1'b0;
      end else if (sync) begin
        cnt    <= '0;
        f2_q   <= 1'b0;
        tick_q <= 1'b0;
        active <= next_div;
        pend_v <= 1'b0;
      end else if (en && terminal) begin
        cnt    <= '0;
        f2_q   <= ~f2_q;
        tick_q <= 1'b1;
        active <= next_div;
        pend_v <= 1'b0;
      end else begin
        if (en) begin
          cnt <= cnt + CNT_W'(1);
        end
        tick_q <= 1'b0;
        if (load_ok) begin
          pend   <= div_value;
          pend_v <= 1'b1;
        end
      end
    end

    assign F2[i]   = f2_q;
    assign tick[i] = tick_q;
  end

`ifdef FREQ_DIV_ERR_EN
  always_ff @(posedge F1 or posedge rst) begin
    if (rst) begin
      div_err <= 1'b0;
    end else begin
      div_err <= (|div_load) && !value_ok;
    end
  end
`endif

endmodule

// File: tb/tb_freq_divider_multi.sv
// tb/tb_freq_divider_multi.sv - randomized self-checking bench for freq_divider_multi
// Reference model tracks edges remaining in each half-period plus pending divide values.
module tb_freq_divider_multi;

  logic        F1 = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic [2:0]  div_load = '0;
  logic [31:0] div_value = '0;
  logic [2:0]  F2;
  logic [2:0]  tick;
  logic        obs_err;
`ifdef FREQ_DIV_ERR_EN
  logic        div_err;
`endif

  freq_divider_multi #(.CHANNELS(3), .CNT_W(32), .DEFAULT_DIV(5)) dut (
    .F1(F1),
    .rst(rst),
    .en(en),
    .sync(sync),
    .div_load(div_load),
    .div_value(div_value),
`ifdef FREQ_DIV_ERR_EN
    .div_err(div_err),
`endif
    .F2(F2),
    .tick(tick)
  );

`ifdef FREQ_DIV_ERR_EN
  assign obs_err = div_err;
`else
  assign obs_err = 1'b0;
`endif

  always #5 F1 = ~F1;

  int n_cmp = 0;
  int n_bad = 0;

  int       m_div [3];
  int       m_rem [3];
  int       m_pend[3];
  bit       m_pv  [3];
  logic [2:0] m_f2;
  logic [2:0] m_tick;
  logic       m_err;

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_div[c] = 5; m_rem[c] = 5; m_pend[c] = 0; m_pv[c] = 0;
    end
    m_f2 = '0; m_tick = '0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    int v;
    bit ld;
    v = int'(div_value);
    for (int c = 0; c < 3; c++) begin
      ld = div_load[c] && (v != 0);
      if (sync) begin
        m_div[c] = ld ? v : (m_pv[c] ? m_pend[c] : m_div[c]);
        m_pv[c] = 0; m_f2[c] = 1'b0; m_tick[c] = 1'b0; m_rem[c] = m_div[c];
      end else begin
        if (en) m_rem[c] = m_rem[c] - 1;
        if (en && m_rem[c] == 0) begin
          m_div[c] = ld ? v : (m_pv[c] ? m_pend[c] : m_div[c]);
          m_pv[c] = 0; m_f2[c] = ~m_f2[c]; m_tick[c] = 1'b1; m_rem[c] = m_div[c];
        end else begin
          m_tick[c] = 1'b0;
          if (ld) begin m_pend[c] = v; m_pv[c] = 1; end
        end
      end
    end
`ifdef FREQ_DIV_ERR_EN
    m_err = (|div_load) && (v == 0);
`else
    m_err = 1'b0;
`endif
  endtask

  task automatic step(input logic e, input logic s, input logic [2:0] ld, input logic [31:0] v);
    en = e; sync = s; div_load = ld; div_value = v;
    @(posedge F1);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge F1);
    rst = 1'b1; en = 1'b0; sync = 1'b0; div_load = '0; div_value = '0;
    @(negedge F1);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge F1);
    rst = 1'b1; en = 1'b1; div_load = 3'b111; div_value = 32'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge F1);
      n_cmp++;
      if ({F2, tick, obs_err} !== 7'b0) begin
        n_bad++;
        $display("FAIL reset k=%0d got f2=%b tick=%b err=%b want 000 000 0", k, F2, tick, obs_err);
      end
    end
    rst = 1'b0; en = 1'b0; div_load = '0; div_value = '0;
    model_reset();
  endtask

  task automatic test_default_period();
    logic [2:0] ef2, et;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, 3'b000, 32'd0);
      et  = (k % 5 == 0) ? 3'b111 : 3'b000;
      ef2 = ((k / 5) % 2 == 1) ? 3'b111 : 3'b000;
      n_cmp++;
      if ({F2, tick} !== {ef2, et}) begin
        n_bad++;
        $display("FAIL default_period k=%0d got f2=%b tick=%b want f2=%b tick=%b", k, F2, tick, ef2, et);
      end
    end
  endtask

  task automatic test_load_commit();
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0, (k == 2) ? 3'b010 : 3'b000, (k == 2) ? 32'd2 : 32'd0);
      n_cmp++;
      if ({F2, tick} !== {m_f2, m_tick}) begin
        n_bad++;
        $display("FAIL load_commit k=%0d got f2=%b tick=%b want f2=%b tick=%b", k, F2, tick, m_f2, m_tick);
      end
    end
  endtask

  task automatic test_last_wins();
    int last, hp;
    do_reset();
    last = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0, (k == 1 || k == 2) ? 3'b001 : 3'b000, (k == 1) ? 32'd7 : 32'd3);
      n_cmp++;
      if ({F2, tick} !== {m_f2, m_tick}) begin
        n_bad++;
        $display("FAIL last_wins k=%0d got f2=%b tick=%b want f2=%b tick=%b", k, F2, tick, m_f2, m_tick);
      end
      if (tick[0]) begin
        hp = k - last;
        last = k;
        n_cmp++;
        if (hp != 5 && hp != 3) begin
          n_bad++;
          $display("FAIL last_wins_halfperiod k=%0d got %0d want 5 or 3", k, hp);
        end
      end
    end
  endtask

  task automatic test_zero_load();
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      step(1'b1, 1'b0, (k == 2) ? 3'b100 : 3'b000, 32'd0);
      n_cmp++;
      if ({F2, tick, obs_err} !== {m_f2, m_tick, m_err}) begin
        n_bad++;
        $display("FAIL zero_load k=%0d got f2=%b tick=%b err=%b want f2=%b tick=%b err=%b",
                 k, F2, tick, obs_err, m_f2, m_tick, m_err);
      end
    end
  endtask

  task automatic test_en_hold();
    logic e;
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      e = !(k >= 4 && k <= 7);
      step(e, 1'b0, 3'b000, 32'd0);
      n_cmp++;
      if ({F2, tick} !== {m_f2, m_tick}) begin
        n_bad++;
        $display("FAIL en_hold k=%0d got f2=%b tick=%b want f2=%b tick=%b", k, F2, tick, m_f2, m_tick);
      end
    end
  endtask

  task automatic test_sync();
    do_reset();
    step(1'b1, 1'b0, 3'b010, 32'd3);
    step(1'b1, 1'b0, 3'b100, 32'd4);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 3'b000, 32'd0);
    step(1'b1, 1'b0, 3'b001, 32'd6);
    step(1'b1, 1'b1, 3'b100, 32'd2);
    n_cmp++;
    if ({F2, tick} !== 6'b0) begin
      n_bad++;
      $display("FAIL sync_clear got f2=%b tick=%b want f2=000 tick=000", F2, tick);
    end
    for (int k = 1; k <= 14; k++) begin
      step(1'b1, 1'b0, 3'b000, 32'd0);
      n_cmp++;
      if ({F2, tick} !== {m_f2, m_tick}) begin
        n_bad++;
        $display("FAIL sync_after k=%0d got f2=%b tick=%b want f2=%b tick=%b", k, F2, tick, m_f2, m_tick);
      end
    end
  endtask

  task automatic test_div1_async_reset();
    do_reset();
    step(1'b1, 1'b0, 3'b111, 32'd1);
    for (int k = 2; k <= 12; k++) begin
      step(1'b1, 1'b0, 3'b000, 32'd0);
      n_cmp++;
      if ({F2, tick} !== {m_f2, m_tick}) begin
        n_bad++;
        $display("FAIL div1 k=%0d got f2=%b tick=%b want f2=%b tick=%b", k, F2, tick, m_f2, m_tick);
      end
      if (k >= 7) begin
        n_cmp++;
        if (tick !== 3'b111) begin
          n_bad++;
          $display("FAIL div1_tick k=%0d got %b want 111", k, tick);
        end
      end
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({F2, tick, obs_err} !== 7'b0) begin
      n_bad++;
      $display("FAIL async_reset got f2=%b tick=%b err=%b want 000 000 0", F2, tick, obs_err);
    end
    @(negedge F1);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic e, s;
    logic [2:0] ld;
    logic [31:0] v;
    do_reset();
    for (int k = 1; k <= 800; k++) begin
      e  = ($urandom_range(0, 9) != 0);
      s  = ($urandom_range(0, 59) == 0);
      ld = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      v  = 32'($urandom_range(0, 9));
      step(e, s, ld, v);
      n_cmp++;
      if ({F2, tick, obs_err} !== {m_f2, m_tick, m_err}) begin
        n_bad++;
        $display("FAIL random k=%0d got f2=%b tick=%b err=%b want f2=%b tick=%b err=%b",
                 k, F2, tick, obs_err, m_f2, m_tick, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_default_period();
    test_load_commit();
    test_last_wins();
    test_zero_load();
    test_en_hold();
    test_sync();
    test_div1_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
